// File: rtl/start_light_sequencer.sv
// Start-light sequencer: steps lights on via the delay block, holds for a random period, then lights out.
// Optional abort input/aborted output enabled by defining SEQ_ABORT_EN.
module start_light_sequencer #(
  parameter int unsigned      WIDTH      = 14,
  parameter int unsigned      NUM_LIGHTS = 5,
  parameter int unsigned      STEP_TICKS = 1000,
  parameter int unsigned      HOLD_BASE  = 200,
  parameter logic [WIDTH-1:0] HOLD_MASK  = 14'h03FF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      rand_val,
  input  logic                  time_out,
`ifdef SEQ_ABORT_EN
  input  logic                  abort,
  output logic                  aborted,
`endif
  output logic                  trigger,
  output logic [WIDTH-1:0]      N,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FIRE      = 3'd1;
  localparam logic [2:0] WAIT      = 3'd2;
  localparam logic [2:0] HOLD_FIRE = 3'd3;
  localparam logic [2:0] HOLD_WAIT = 3'd4;

  localparam int unsigned        STEP_W    = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
  localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(NUM_LIGHTS - 1);
  localparam logic [WIDTH-1:0]   STEP_N    = WIDTH'(STEP_TICKS);
  localparam logic [WIDTH:0]     BASE_X    = (WIDTH + 1)'(HOLD_BASE);

  logic [2:0]            state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [WIDTH-1:0]      n_q, n_d;
  logic [NUM_LIGHTS-1:0] lights_q, lights_d;
  logic                  trigger_q, trigger_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;

  logic [WIDTH:0]        hold_sum;
  logic [WIDTH-1:0]      hold_n;

  // One extra bit catches overflow so the hold length saturates instead of wrapping.
  always_comb begin
    hold_sum = BASE_X + {1'b0, rand_val & HOLD_MASK};
    if (hold_sum[WIDTH]) begin
      hold_n = '1;
    end else if (hold_sum[WIDTH-1:0] == '0) begin
      hold_n = WIDTH'(1);
    end else begin
      hold_n = hold_sum[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    n_d       = n_q;
    lights_d  = lights_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FIRE;
          step_d  = '0;
          n_d     = STEP_N;
        end
      end
      FIRE: state_d = WAIT;
      WAIT: begin
        if (time_out) begin
          lights_d[step_q] = 1'b1;
          if (step_q == LAST_STEP) begin
            n_d     = hold_n;
            state_d = HOLD_FIRE;
          end else begin
            step_d  = step_q + STEP_W'(1);
            n_d     = STEP_N;
            state_d = FIRE;
          end
        end
      end
      HOLD_FIRE: state_d = HOLD_WAIT;
      HOLD_WAIT: begin
        if (time_out) begin
          lights_d = '0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SEQ_ABORT_EN
    // Abort wins over a time_out arriving on the same edge; N is left as-is.
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      step_d    = '0;
      lights_d  = '0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
`endif
  end

  assign trigger_d = (state_d == FIRE) || (state_d == HOLD_FIRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      step_q    <= '0;
      n_q       <= STEP_N;
      lights_q  <= '0;
      trigger_q <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      n_q       <= n_d;
      lights_q  <= lights_d;
      trigger_q <= trigger_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign trigger = trigger_q;
  assign N       = n_q;
  assign lights  = lights_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);
`ifdef SEQ_ABORT_EN
  assign aborted = aborted_q;
`else
  logic unused_aborted;
  assign unused_aborted = aborted_q ^ aborted_d;
`endif

endmodule

// File: tb/tb_start_light_sequencer.sv
// Scoreboard bench: three sequencers with different hold configurations share one stimulus stream.
// Exercises the SEQ_ABORT_EN abort path as well when that macro is defined.
module tb_start_light_sequencer;

  localparam int W  = 14;
  localparam int NL = 5;
  localparam int ST = 4;

  localparam int unsigned BASE_T [3] = '{200, 'h3F00, 0};
  localparam logic [W-1:0] MASK_T [3] = '{14'h03FF, 14'h3FFF, 14'h3FFF};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic time_out = 1'b0;
  logic [W-1:0] rand_val = '0;
`ifdef SEQ_ABORT_EN
  logic abort = 1'b0;
  logic [2:0] aborted;
`endif

  logic [2:0] trig, done, busy;
  logic [2:0][W-1:0] n_o;
  logic [2:0][NL-1:0] lt;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    start_light_sequencer #(
      .WIDTH(W), .NUM_LIGHTS(NL), .STEP_TICKS(ST),
      .HOLD_BASE(BASE_T[gi]), .HOLD_MASK(MASK_T[gi])
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .rand_val(rand_val),
      .time_out(time_out),
`ifdef SEQ_ABORT_EN
      .abort(abort),
      .aborted(aborted[gi]),
`endif
      .trigger(trig[gi]),
      .N(n_o[gi]),
      .lights(lt[gi]),
      .busy(busy[gi]),
      .done(done[gi])
    );
  end

  typedef struct {
    bit           is_done;
    logic [W-1:0] n0, n1, n2;
    logic [NL-1:0] lights;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_trig_seen = 0;
  int n_trig_exp = 0;
  bit prev_trig = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference hold length straight from the rule: base + masked random, clamp to max, never zero.
  function automatic logic [W-1:0] hold_ref(input int unsigned base, input int unsigned mask,
                                             input int unsigned r);
    longint s;
    s = longint'(base) + longint'(r & mask);
    if (s > longint'((1 << W) - 1)) s = (1 << W) - 1;
    if (s == 0) s = 1;
    return W'(s);
  endfunction

  task automatic push_steps();
    exp_t e;
    for (int k = 0; k < NL; k++) begin
      e.is_done = 1'b0;
      e.n0 = W'(ST); e.n1 = W'(ST); e.n2 = W'(ST);
      e.lights = NL'((1 << k) - 1);
      sb.push_back(e);
      n_trig_exp++;
    end
  endtask

  task automatic push_hold(input int unsigned r);
    exp_t e;
    e.is_done = 1'b0;
    e.n0 = hold_ref(BASE_T[0], MASK_T[0], r);
    e.n1 = hold_ref(BASE_T[1], MASK_T[1], r);
    e.n2 = hold_ref(BASE_T[2], MASK_T[2], r);
    e.lights = '1;
    sb.push_back(e);
    n_trig_exp++;
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.n0 = '0; e.n1 = '0; e.n2 = '0;
    e.lights = '0;
    sb.push_back(e);
  endtask

  task automatic flush();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (!e.is_done) n_trig_exp--;
    end
  endtask

  // Monitor: every trigger or done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((|trig) || (|done))) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: trig=%b done=%b, required no pulse (t=%0t)", trig, done, $time);
      end else begin
        e = sb.pop_front();
        if (e.is_done) begin
          chk("done_pulse", done, 3'b111);
          chk("done_trig", trig, 3'b000);
          chk("done_lights", lt, '0);
          chk("done_busy", busy, 3'b000);
        end else begin
          n_trig_seen++;
          chk("trig_pulse", trig, 3'b111);
          chk("trig_done", done, 3'b000);
          chk("trig_busy", busy, 3'b111);
          chk("trig_lights", lt, {3{e.lights}});
          chk("trig_N_base", n_o[0], e.n0);
          chk("trig_N_sat", n_o[1], e.n1);
          chk("trig_N_zero", n_o[2], e.n2);
        end
      end
    end
    if (trig[0]) chk("trig_gap", prev_trig, 1'b0);
    prev_trig = trig[0];
  end

  task automatic wait_trig(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (trig[0]) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    n_cmp++;
    n_err++;
    $display("FAIL trigger_timeout: trigger=0 after 50 cycles, required 1 (t=%0t)", $time);
  endtask

  // Plays the delay block: answers each trigger with a time_out some cycles later.
  task automatic run_seq(input bit fixed_lat, input bit keep_start, input bit pre_pushed,
                         input int force_rand, input int abort_at, input int rst_at);
    bit ok;
    int lat;
    if (pre_pushed) begin
      @(negedge clk);
      chk("restart_gap", trig[0], 1'b1);
      if (!keep_start) start = 1'b0;
    end else begin
      push_steps();
      start = 1'b1;
      @(negedge clk);
      if (!keep_start) start = 1'b0;
    end
    for (int s = 0; s <= NL; s++) begin
      wait_trig(ok);
      if (!ok) begin
        flush();
        start = 1'b0;
        return;
      end
      if (s == rst_at) begin
        chk("pre_reset_lights", lt[0], NL'(7));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_lights", lt, '0);
        chk("async_rst_trig", trig, 3'b000);
        chk("async_rst_busy", busy, 3'b000);
        flush();
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (!fixed_lat && ($urandom_range(0, 3) == 0)) begin
        time_out = 1'b1;
        @(negedge clk);
        time_out = 1'b0;
      end
      lat = fixed_lat ? 4 : int'($urandom_range(1, 5));
      repeat (lat) begin
        @(negedge clk);
        rand_val = W'($urandom);
      end
      if (s == NL - 1) begin
        if (force_rand >= 0) rand_val = W'(force_rand);
        push_hold(int'(rand_val));
      end
      if (s == NL) begin
        push_done();
        if (keep_start) push_steps();
      end
`ifdef SEQ_ABORT_EN
      if (s == abort_at) abort = 1'b1;
`endif
      time_out = 1'b1;
      @(negedge clk);
      time_out = 1'b0;
      rand_val = W'($urandom);
`ifdef SEQ_ABORT_EN
      if (s == abort_at) begin
        abort = 1'b0;
        chk("abort_pulse", aborted, 3'b111);
        chk("abort_lights", lt, '0);
        chk("abort_done", done, 3'b000);
        chk("abort_busy", busy, 3'b000);
        flush();
        start = 1'b0;
        @(negedge clk);
        chk("abort_pulse_end", aborted, 3'b000);
        return;
      end
`endif
    end
  endtask

  task automatic idle_poke();
    time_out = 1'b1;
    @(negedge clk);
    time_out = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_lights", lt, '0);
    chk("idle_busy", busy, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig", trig, 3'b000);
    chk("rst_done", done, 3'b000);
    chk("rst_busy", busy, 3'b000);
    chk("rst_lights", lt, '0);
    chk("rst_N", n_o, {3{W'(ST)}});
    rst_n = 1'b1;
    @(negedge clk);

    run_seq(1'b1, 1'b0, 1'b0, 'h3FFF, -1, -1);
    idle_poke();
    run_seq(1'b0, 1'b0, 1'b0, 0, -1, -1);
    run_seq(1'b0, 1'b1, 1'b0, -1, -1, -1);
    run_seq(1'b0, 1'b0, 1'b1, -1, -1, -1);
    run_seq(1'b0, 1'b0, 1'b0, -1, -1, 3);
    idle_poke();
`ifdef SEQ_ABORT_EN
    run_seq(1'b0, 1'b0, 1'b0, -1, 2, -1);
    idle_poke();
`endif
    repeat (8) begin
      run_seq(1'b0, 1'b0, 1'b0, -1, -1, -1);
      if ($urandom_range(0, 1) == 1) idle_poke();
    end

    repeat (20) @(negedge clk);
    chk("queue_empty", sb.size(), 0);
    chk("trigger_count", n_trig_seen, n_trig_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
